// File: rtl/surfboard_seq_ctrl.sv
// -----------------------------------------------------------------------------
// surfboard_seq_ctrl
//
// Sequential 3x3 matrix multiplier C = A x B. It uses one shared
// multiply-accumulate unit, so the product takes 27 cycles instead of the
// 27 parallel multipliers of the combinational version. The low W bits of
// every result match that combinational block exactly.
//
// Flow: LOAD (18 input elements) -> COMPUTE (27 cycles) -> DRAIN (9 output
// elements) -> LOAD.
//
// Parameters
//   W       element width of A, B and C
//   SIGNED  1 = operands are two's complement, 0 = unsigned (the low W result
//           bits are the same in both modes)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort back to LOAD; all data is discarded
//   in_valid   input element valid
//   in_ready   controller accepts an input element (LOAD only)
//   in_data    input stream: A[0..8] followed by B[0..8], row-major
//   out_valid  C element valid (DRAIN only)
//   out_ready  downstream accepts the C element
//   out_data   C element, row-major C[0..8]; zero outside DRAIN
//   out_last   high together with C[8]
//   busy       high in COMPUTE or DRAIN
//   done       single-cycle pulse after the C[8] handshake
// -----------------------------------------------------------------------------
module surfboard_seq_ctrl #(
  parameter int W      = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  localparam logic [4:0] LD_LAST  = 5'd17;
  localparam logic [4:0] LD_B_OFS = 5'd9;
  localparam logic [3:0] OUT_LAST = 4'd8;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic [4:0]   ld_cnt_q, ld_cnt_d;
  logic [1:0]   i_q, i_d;
  logic [1:0]   j_q, j_d;
  logic [1:0]   k_q, k_d;
  logic [3:0]   out_cnt_q, out_cnt_d;
  logic [W-1:0] acc_q, acc_d;
  logic         done_q, done_d;
  // Low during reset and set on the first clock afterwards, so in_ready stays
  // low while reset is asserted even though the state is already LOAD.
  logic         alive_q;

  // Operand and result storage
  logic [W-1:0] a_mem [9];
  logic [W-1:0] b_mem [9];
  logic [W-1:0] c_mem [9];

  // ---------------------------------------------------------------------------
  // Handshakes and outputs
  // ---------------------------------------------------------------------------
  logic in_hs;
  logic out_hs;

  assign in_ready  = (state_q == ST_LOAD) && alive_q;
  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = (state_q == ST_DRAIN) && (out_cnt_q == OUT_LAST);
  assign busy      = (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
  assign done      = done_q;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // C storage is never reset, so the output is gated to read zero outside DRAIN.
  assign out_data  = (state_q == ST_DRAIN) ? c_mem[out_cnt_q] : '0;

  // ---------------------------------------------------------------------------
  // Load-side addressing: ld_cnt 0..8 selects A, 9..17 selects B.
  // ---------------------------------------------------------------------------
  logic       ld_is_a;
  logic [3:0] ld_idx;
  logic [4:0] ld_b_ofs;

  always_comb begin
    ld_is_a  = (ld_cnt_q < LD_B_OFS);
    ld_b_ofs = ld_cnt_q - LD_B_OFS;
    ld_idx   = ld_is_a ? ld_cnt_q[3:0] : ld_b_ofs[3:0];
  end

  // ---------------------------------------------------------------------------
  // Multiply-accumulate: acc = (k==0 ? 0 : acc) + trunc_W(A[3i+k] * B[3k+j])
  // ---------------------------------------------------------------------------
  logic [3:0]     a_idx, b_idx, c_idx;
  logic [W-1:0]   a_op, b_op;
  logic [2*W-1:0] a_ext, b_ext;
  logic [W-1:0]   prod;
  logic [W-1:0]   mac_sum;

  always_comb begin
    a_idx = ({2'b00, i_q} * 4'd3) + {2'b00, k_q};
    b_idx = ({2'b00, k_q} * 4'd3) + {2'b00, j_q};
    c_idx = ({2'b00, i_q} * 4'd3) + {2'b00, j_q};
    a_op  = a_mem[a_idx];
    b_op  = b_mem[b_idx];
    // Extending to 2W before multiplying gives the true signed or unsigned
    // product; only its low W bits are kept, and those do not depend on the
    // mode.
    if (SIGNED) begin
      a_ext = {{W{a_op[W-1]}}, a_op};
      b_ext = {{W{b_op[W-1]}}, b_op};
    end else begin
      a_ext = {{W{1'b0}}, a_op};
      b_ext = {{W{1'b0}}, b_op};
    end
    prod    = W'(a_ext * b_ext);
    mac_sum = ((k_q == 2'd0) ? '0 : acc_q) + prod;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    out_cnt_d = out_cnt_q;
    acc_d     = acc_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (in_hs) begin
          if (ld_cnt_q == LD_LAST) begin
            ld_cnt_d = '0;
            state_d  = ST_COMPUTE;
          end else begin
            ld_cnt_d = ld_cnt_q + 5'd1;
          end
        end
      end

      ST_COMPUTE: begin
        acc_d = mac_sum;
        // k is the innermost counter, then j, then i.
        if (k_q == 2'd2) begin
          k_d = '0;
          if (j_q == 2'd2) begin
            j_d = '0;
            if (i_q == 2'd2) begin
              i_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              i_d = i_q + 2'd1;
            end
          end else begin
            j_d = j_q + 2'd1;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      ST_DRAIN: begin
        if (out_hs) begin
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d = '0;
            state_d   = ST_LOAD;
            done_d    = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + 4'd1;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase

    // clear overrides everything above, including a same-cycle handshake and
    // the done pulse of a final C[8] handshake.
    if (clear) begin
      state_d   = ST_LOAD;
      ld_cnt_d  = '0;
      i_d       = '0;
      j_d       = '0;
      k_d       = '0;
      out_cnt_d = '0;
      acc_d     = '0;
      done_d    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      ld_cnt_q  <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      out_cnt_q <= '0;
      acc_q     <= '0;
      done_q    <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      out_cnt_q <= out_cnt_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
      alive_q   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage writes
  // ---------------------------------------------------------------------------
  // NOTE: the A/B/C arrays are deliberately left out of reset. Every entry is
  // written before it is read, and no reset keeps them as plain RAM.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (in_hs) begin
        if (ld_is_a) begin
          a_mem[ld_idx] <= in_data;
        end else begin
          b_mem[ld_idx] <= in_data;
        end
      end
      if ((state_q == ST_COMPUTE) && (k_q == 2'd2)) begin
        c_mem[c_idx] <= mac_sum;
      end
    end
  end

endmodule

// File: tb/tb_surfboard_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_surfboard_seq_ctrl
//
// Directed bench for surfboard_seq_ctrl (W=4). It drives a signed instance and
// an unsigned instance from the same stimulus, and both must produce the same
// hand-computed C stream. Inputs change 1 time unit after the rising edge, and
// outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_surfboard_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready,  in_ready_u;
  logic         out_valid, out_valid_u;
  logic [W-1:0] out_data,  out_data_u;
  logic         out_last,  out_last_u;
  logic         busy,      busy_u;
  logic         done,      done_u;

  surfboard_seq_ctrl #(.W(W), .SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  surfboard_seq_ctrl #(.W(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .out_last(out_last_u), .busy(busy_u), .done(done_u)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] job_a [9];
  logic [W-1:0] job_b [9];
  logic [W-1:0] exp_c [9];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams A then B. With gaps set, idle cycles are inserted at random.
  // Returns 1 unit after the edge that carries the 18th handshake.
  task automatic send_job(input bit gaps);
    for (int n = 0; n < 18; n++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      in_valid = 1'b1;
      in_data  = (n < 9) ? job_a[n] : job_b[n-9];
      for (int g = 0; g < 50 && !in_ready; g++) tick();
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Checks that the job starts and then counts cycles until out_valid;
  // the first C element is due 27 edges after the last input handshake.
  task automatic wait_result(input string tag);
    int lat;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd27);
  endtask

  // Accepts the C stream. At element stall_idx out_ready is held low for
  // stall_cycles cycles first. At element abort_idx the task returns before
  // that element's handshake.
  task automatic collect(input string tag, input int stall_idx, input int stall_cycles,
                         input int abort_idx);
    for (int e = 0; e < 9; e++) begin
      check($sformatf("%s_valid%0d", tag, e), 32'(out_valid), 32'd1);
      check($sformatf("%s_c%0d", tag, e), 32'(out_data), 32'(exp_c[e]));
      check($sformatf("%s_cu%0d", tag, e), 32'(out_data_u), 32'(exp_c[e]));
      check($sformatf("%s_last%0d", tag, e), 32'(out_last), 32'(e == 8));
      if (e == abort_idx) return;
      if (e == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          check($sformatf("%s_hold_c%0d_%0d", tag, e, s), 32'(out_data), 32'(exp_c[e]));
          check($sformatf("%s_hold_v%0d_%0d", tag, e, s), 32'(out_valid), 32'd1);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_u"}, 32'(done_u), 32'd1);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit seen;

    // Reset values
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_still_low", 32'(in_ready), 32'd0);
    tick();
    check("rel_in_ready_high", 32'(in_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);

    // Identity A times B = 0..8 gives C = 0..8
    job_a = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
    job_b = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    exp_c = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    send_job(1'b0);
    wait_result("ident");
    collect("ident", -1, 0, -1);

    // Wrap: every term is 7*7 = 49 = 1 mod 16, so each C element is 3
    job_a = '{default: 4'd7};
    job_b = '{default: 4'd7};
    exp_c = '{default: 4'd3};
    send_job(1'b0);
    wait_result("wrap");
    collect("wrap", -1, 0, -1);

    // Signed: A all -1, B = I gives C all -1 (0xF), also from the unsigned instance
    job_a = '{default: 4'hF};
    job_b = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
    exp_c = '{default: 4'hF};
    send_job(1'b0);
    wait_result("signed");
    collect("signed", -1, 0, -1);

    // Backpressure on C[4] and random input gaps.
    // A=[1 2 3;4 5 6;7 8 9], B=[1 0 1;0 1 0;1 0 1]
    // C=[4 2 4;10 5 10;16 8 16] -> mod 16 [4 2 4;10 5 10;0 8 0]
    job_a = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    job_b = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
    exp_c = '{4'd4, 4'd2, 4'd4, 4'd10, 4'd5, 4'd10, 4'd0, 4'd8, 4'd0};
    send_job(1'b1);
    wait_result("bp");
    collect("bp", 4, 5, -1);

    // clear in the 10th COMPUTE cycle, then a fresh job with the same matrices
    send_job(1'b0);
    check("clr_busy_before", 32'(busy), 32'd1);
    repeat (9) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_in_ready", 32'(in_ready), 32'd1);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid || done || busy) seen = 1'b1;
      tick();
    end
    check("clr_stays_idle", 32'(seen), 32'd0);
    send_job(1'b0);
    wait_result("post_clr");
    collect("post_clr", -1, 0, -1);

    // Reset while C[2] is presented, then a full new job
    job_a = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
    job_b = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    exp_c = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    send_job(1'b0);
    wait_result("rstd");
    collect("rstd", -1, 0, 2);
    rst_n = 1'b0;
    #1;
    check("rstd_out_valid", 32'(out_valid), 32'd0);
    check("rstd_out_data", 32'(out_data), 32'd0);
    check("rstd_out_last", 32'(out_last), 32'd0);
    check("rstd_busy", 32'(busy), 32'd0);
    check("rstd_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rstd_in_ready_back", 32'(in_ready), 32'd1);
    job_a = '{default: 4'd7};
    job_b = '{default: 4'd7};
    exp_c = '{default: 4'd3};
    send_job(1'b0);
    wait_result("post_rst");
    collect("post_rst", -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/surfboard_seq_ctrl.md
Name: surfboard_seq_ctrl

Overview:
Sequential controller and datapath for the 3x3 matrix product C = A x B. It accepts A and B as a single element stream and computes with one shared multiply-accumulate unit over 27 cycles. It then streams C out under valid/ready backpressure. Arithmetic is bit-identical to the team's combinational 3x3 surfboard multiplier, so it serves as the area-reduced alternative for the same datapath slot.

Parameters:
W, 4, element width in bits for A, B and C
SIGNED, 1, 1 = operands treated as two's complement, 0 = unsigned; the low W result bits are identical in both modes, and the parameter is kept for interface parity

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: return to LOAD, discard all data
in_valid  input  1  input element valid
in_ready  output  1  controller can accept an input element
in_data  input  W  element: A[0..8] then B[0..8], row-major
out_valid  output  1  C element valid
out_ready  input  1  downstream accepts C element
out_data  output  W  C element, row-major C[0..8]
out_last  output  1  high with C[8]
busy  output  1  high in COMPUTE or DRAIN
done  output  1  one-cycle pulse after C[8] handshake

Behaviour:
- Reset (rst_n=0, async):
  - state=LOAD; all counters 0; in_ready=0 during reset and 1 from the first clock after release.
  - out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - A/B/C storage is not required to reset.
- States: LOAD -> COMPUTE -> DRAIN -> LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready handshake stores in_data at index ld_cnt (0..17); ld_cnt 0-8 fill A[0..8], 9-17 fill B[0..8].
  - Gaps in in_valid are allowed. The handshake at ld_cnt=17 moves to COMPUTE on the next cycle.
- COMPUTE:
  - in_ready=0, busy=1.
  - Nested counters run i (row, outer), j (col), k (inner). Each cycle performs acc = (k==0 ? 0 : acc) + trunc_W(A[3i+k]*B[3k+j]).
  - Products and sums wrap modulo 2^W, with no saturation and no width growth.
  - At k==2 the final sum is written to C[3i+j].
  - Exactly 27 cycles; the cycle after (i,j,k)=(2,2,2) enters DRAIN.
- Latency: last input handshake at cycle t -> COMPUTE during t+1..t+27 -> out_valid=1 with C[0] at t+28.
- DRAIN:
  - out_valid=1, out_data=C[out_cnt], out_last=(out_cnt==8).
  - out_data and out_last are held stable while out_valid & !out_ready. out_cnt advances only on handshake.
  - The handshake on C[8] returns to LOAD next cycle with done=1 for that single cycle, in_ready=1 in the same cycle, and out_valid=0.
- clear (any state):
  - Next state is LOAD; counters are zeroed; out_valid, out_last and busy drop next cycle; done is not pulsed.
  - clear has priority over a same-cycle handshake: that handshake's element is discarded, but the upstream/downstream side still observes it as accepted.
- Mid-operation rst_n assertion aborts immediately to the reset values. There is no partial output.
- Signed mode: storage and accumulation are mode-independent because the low W bits of the product do not depend on signedness. Implement the product from signed or unsigned operands per SIGNED and truncate.
- Back-to-back jobs: the next job's A[0] may be accepted in the cycle done=1.

Test Plan:
- Identity: A=I (1 on diagonal), B=0..8 -> C=0..8 in order, out_last on C[8], done one cycle later, first out_valid exactly 28 cycles after the 18th in handshake.
- Wrap: W=4, A=all 7, B=all 7 -> 49 mod 16 = 1 per term, so every C element = 3.
- Signed: A=all 0xF (-1), B=I -> C all 0xF. With SIGNED=0 the C stream is identical.
- Backpressure: hold out_ready=0 for 5 cycles while C[4] is presented -> out_data holds C[4], out_cnt holds, and there are no duplicate or skipped elements. Randomized in_valid gaps still yield the same C.
- clear at COMPUTE cycle 10 -> LOAD next cycle, in_ready=1, busy=0, no done pulse. A fresh job then produces the correct C.
- rst_n low during DRAIN at C[2] -> out_valid=0 immediately. After release a full new job completes correctly.
